// File: rtl/monitor_pkg.sv
// Frame layout and FSM encoding shared by the monitor SPI reader and the monitor slave.
package monitor_pkg;

  localparam int FRAME_BITS = 40;
  localparam int ADDR_WIDTH = 24;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_HIGH     = 3'd2,
    ST_LOW      = 3'd3,
    ST_DESELECT = 3'd4
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] frame_addr(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1 -: ADDR_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] frame_data(input logic [FRAME_BITS-1:0] frame);
    return frame[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/monitor_reader_sync.sv
// Two-flop synchronizer for the serial input; both flops clear to 0 on reset.
module monitor_reader_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/monitor_reader.sv
// Host-side SPI reader: generates SPICLK/SPISS, shifts in one 40-bit address/data
// frame MSB first, and strobes VALID_OUT when the captured fields update.
module monitor_reader
  import monitor_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic        CLK_IN,
  input  logic        RESET_N_IN,
  input  logic        START_IN,
  input  logic        SPISI_IN,
  output logic        SPICLK_OUT,
  output logic        SPISS_OUT,
  output logic [23:0] ADDR_OUT,
  output logic [15:0] DATA_OUT,
  output logic        VALID_OUT,
  output logic        BUSY_OUT,
  output logic [2:0]  STATE_DBG_OUT
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  state_e                  state_q;
  logic [PW-1:0]           phase_q;
  logic [5:0]              bit_cnt_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    spiclk_q;
  logic                    spiss_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    spisi_sync;
  logic                    phase_last;

  monitor_reader_sync u_sync (
    .clk_i  (CLK_IN),
    .rst_ni (RESET_N_IN),
    .d_i    (SPISI_IN),
    .q_o    (spisi_sync)
  );

  assign phase_last = (phase_q == PH_LAST);

  // Each non-idle state lasts HALF_PERIOD cycles; the bit is taken on the last
  // HIGH cycle, i.e. just before SPICLK falls, after the slave has driven it.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      spiclk_q  <= 1'b0;
      spiss_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          spiclk_q <= 1'b0;
          spiss_q  <= 1'b0;
          if (START_IN) begin
            state_q   <= ST_SELECT;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            spiss_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (phase_last) begin
            state_q  <= ST_HIGH;
            phase_q  <= '0;
            spiclk_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_HIGH: begin
          if (phase_last) begin
            state_q   <= ST_LOW;
            phase_q   <= '0;
            spiclk_q  <= 1'b0;
            shift_q   <= {shift_q[FRAME_BITS-2:0], spisi_sync};
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_LOW: begin
          if (phase_last) begin
            phase_q <= '0;
            if (bit_cnt_q == 6'(FRAME_BITS)) begin
              state_q <= ST_DESELECT;
              spiss_q <= 1'b0;
            end else begin
              state_q  <= ST_HIGH;
              spiclk_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_DESELECT: begin
          if (phase_last) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            addr_q  <= frame_addr(shift_q);
            data_q  <= frame_data(shift_q);
            valid_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          phase_q  <= '0;
          spiclk_q <= 1'b0;
          spiss_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign SPICLK_OUT    = spiclk_q;
  assign SPISS_OUT     = spiss_q;
  assign ADDR_OUT      = addr_q;
  assign DATA_OUT      = data_q;
  assign VALID_OUT     = valid_q;
  assign BUSY_OUT      = busy_q;
  assign STATE_DBG_OUT = state_q;

endmodule

// File: tb/tb_monitor_reader.sv
// Directed bench for monitor_reader: H=4 and H=3 instances, each fed by a small
// behavioural monitor slave that drives the next frame bit after every SPICLK rise.
module tb_monitor_reader;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        spisi_a;
  logic        spiclk_a;
  logic        spiss_a;
  logic [23:0] addr_a;
  logic [15:0] data_a;
  logic        valid_a;
  logic        busy_a;
  logic [2:0]  state_a;

  logic        start_b;
  logic        spisi_b;
  logic        spiclk_b;
  logic        spiss_b;
  logic [23:0] addr_b;
  logic [15:0] data_b;
  logic        valid_b;
  logic        busy_b;
  logic [2:0]  state_b;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  monitor_reader #(.HALF_PERIOD(4)) dut_a (
    .CLK_IN        (clk),
    .RESET_N_IN    (rst_n),
    .START_IN      (start_a),
    .SPISI_IN      (spisi_a),
    .SPICLK_OUT    (spiclk_a),
    .SPISS_OUT     (spiss_a),
    .ADDR_OUT      (addr_a),
    .DATA_OUT      (data_a),
    .VALID_OUT     (valid_a),
    .BUSY_OUT      (busy_a),
    .STATE_DBG_OUT (state_a)
  );

  monitor_reader #(.HALF_PERIOD(3)) dut_b (
    .CLK_IN        (clk),
    .RESET_N_IN    (rst_n),
    .START_IN      (start_b),
    .SPISI_IN      (spisi_b),
    .SPICLK_OUT    (spiclk_b),
    .SPISS_OUT     (spiss_b),
    .ADDR_OUT      (addr_b),
    .DATA_OUT      (data_b),
    .VALID_OUT     (valid_b),
    .BUSY_OUT      (busy_b),
    .STATE_DBG_OUT (state_b)
  );

  // ---------------- behavioural monitor slaves ----------------
  logic [39:0] frame_a = '0;
  logic [39:0] frame_b = '0;
  int idx_a = 0, rises_a = 0, stray_a = 0;
  int idx_b = 0, rises_b = 0, stray_b = 0;
  logic prev_clk_a = 1'b0, prev_clk_b = 1'b0;

  initial begin
    spisi_a = 1'bz;
    spisi_b = 1'bz;
  end

  always @(negedge clk) begin
    if (spiclk_a && !prev_clk_a && !spiss_a) stray_a = stray_a + 1;
    if (!spiss_a) begin
      spisi_a = 1'bz;
      idx_a   = 0;
    end else if (spiclk_a && !prev_clk_a) begin
      if (idx_a < 40) spisi_a = frame_a[39 - idx_a];
      idx_a   = idx_a + 1;
      rises_a = rises_a + 1;
    end
    prev_clk_a = spiclk_a;
  end

  always @(negedge clk) begin
    if (spiclk_b && !prev_clk_b && !spiss_b) stray_b = stray_b + 1;
    if (!spiss_b) begin
      spisi_b = 1'bz;
      idx_b   = 0;
    end else if (spiclk_b && !prev_clk_b) begin
      if (idx_b < 40) spisi_b = frame_b[39 - idx_b];
      idx_b   = idx_b + 1;
      rises_b = rises_b + 1;
    end
    prev_clk_b = spiclk_b;
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One frame on instance A: latency 82*4+1 = 329, fields must hold until VALID.
  task automatic do_frame_a(input logic [23:0] a, input logic [15:0] d,
                            input logic [23:0] pa, input logic [15:0] pd, input bit poke);
    int cyc;
    int r0;
    int s0;
    int nv;
    frame_a = {a, d};
    r0 = rises_a;
    s0 = stray_a;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check_eq("busy_k1", 40'(busy_a), 40'd1);
    check_eq("spiss_k1", 40'(spiss_a), 40'd1);
    cyc = 1;
    while (!valid_a && cyc < 1000) begin
      if (cyc == 100) begin
        check_eq("addr_hold_mid", 40'(addr_a), 40'(pa));
        check_eq("data_hold_mid", 40'(data_a), 40'(pd));
      end
      start_a = (poke && (cyc == 60 || cyc == 250)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    check_eq("valid_latency", 40'(cyc), 40'd329);
    check_eq("addr", 40'(addr_a), 40'(a));
    check_eq("data", 40'(data_a), 40'(d));
    check_eq("busy_at_valid", 40'(busy_a), 40'd1);
    check_eq("spiclk_rises", 40'(rises_a - r0), 40'd40);
    check_eq("stray_rises", 40'(stray_a - s0), 40'd0);
    @(negedge clk);
    check_eq("valid_one_cycle", 40'(valid_a), 40'd0);
    check_eq("busy_falls", 40'(busy_a), 40'd0);
    if (poke) begin
      nv = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (valid_a) nv++;
      end
      check_eq("no_queued_frame", 40'(nv), 40'd0);
      check_eq("idle_after_poke", 40'(state_a), 40'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int r0;
    int vcnt;
    int vt[3];
    int gap_cur;
    int ngaps;
    int min_gap;
    bit seen_ss;

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check_eq("rst_spiclk", 40'(spiclk_a), 40'd0);
    check_eq("rst_spiss", 40'(spiss_a), 40'd0);
    check_eq("rst_addr", 40'(addr_a), 40'd0);
    check_eq("rst_data", 40'(data_a), 40'd0);
    check_eq("rst_valid", 40'(valid_a), 40'd0);
    check_eq("rst_busy", 40'(busy_a), 40'd0);
    check_eq("rst_state", 40'(state_a), 40'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic frame, START pokes while busy are ignored
    do_frame_a(24'h123456, 16'hBEEF, 24'h000000, 16'h0000, 1'b1);
    // bit ordering / no stale bits
    do_frame_a(24'hFFFFFF, 16'h0000, 24'h123456, 16'hBEEF, 1'b0);
    do_frame_a(24'h000000, 16'hFFFF, 24'hFFFFFF, 16'h0000, 1'b0);

    // reset asserted after bit 20
    frame_a = {24'h777777, 16'h7777};
    r0 = rises_a;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while ((rises_a - r0) < 20 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bit20_reached", 40'(rises_a - r0), 40'd20);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_spiss", 40'(spiss_a), 40'd0);
    check_eq("midrst_spiclk", 40'(spiclk_a), 40'd0);
    check_eq("midrst_valid", 40'(valid_a), 40'd0);
    check_eq("midrst_busy", 40'(busy_a), 40'd0);
    check_eq("midrst_data", 40'(data_a), 40'd0);
    check_eq("midrst_state", 40'(state_a), 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("postrst_no_valid", 40'(valid_a), 40'd0);
    do_frame_a(24'hA5C3E1, 16'h5A3C, 24'h000000, 16'h0000, 1'b0);

    // START held high for three frames
    frame_a = {24'h0F0F0F, 16'hF0F0};
    vcnt = 0;
    gap_cur = 0;
    ngaps = 0;
    min_gap = 1000;
    seen_ss = 1'b0;
    cyc = 0;
    start_a = 1'b1;
    while (vcnt < 3 && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      if (spiss_a) begin
        if (seen_ss && gap_cur > 0) begin
          ngaps++;
          if (gap_cur < min_gap) min_gap = gap_cur;
        end
        seen_ss = 1'b1;
        gap_cur = 0;
      end else if (seen_ss) begin
        gap_cur++;
      end
      if (valid_a) begin
        vt[vcnt] = cyc;
        vcnt++;
      end
    end
    start_a = 1'b0;
    check_eq("held_valid_count", 40'(vcnt), 40'd3);
    check_eq("held_spacing_1", 40'(vt[1] - vt[0]), 40'd329);
    check_eq("held_spacing_2", 40'(vt[2] - vt[1]), 40'd329);
    check_eq("held_gap_count", 40'(ngaps), 40'd2);
    check_eq("held_gap_min_ge_h", 40'(min_gap >= 4), 40'd1);
    check_eq("held_addr", 40'(addr_a), 40'h0F0F0F);
    check_eq("held_data", 40'(data_a), 40'hF0F0);
    repeat (3) @(negedge clk);
    check_eq("held_stops", 40'(busy_a), 40'd0);

    // H=3 instance: Z on SPISI while deselected must not disturb outputs
    check_eq("h3_idle_addr", 40'(addr_b), 40'd0);
    check_eq("h3_idle_known", 40'($isunknown({addr_b, data_b, valid_b, busy_b, spiclk_b, spiss_b})), 40'd0);
    frame_b = {24'h3C5A96, 16'h1234};
    r0 = rises_b;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    while (!valid_b && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("h3_latency", 40'(cyc), 40'd247);
    check_eq("h3_addr", 40'(addr_b), 40'h3C5A96);
    check_eq("h3_data", 40'(data_b), 40'h1234);
    check_eq("h3_rises", 40'(rises_b - r0), 40'd40);
    check_eq("h3_stray", 40'(stray_b), 40'd0);
    repeat (20) @(negedge clk);
    check_eq("h3_hold_addr", 40'(addr_b), 40'h3C5A96);
    check_eq("h3_out_known", 40'($isunknown({addr_b, data_b, valid_b, busy_b, spiclk_b, spiss_b})), 40'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
